// File: rtl/sel_decode_checker_pkg.sv
// sel_check_pkg: shared types and helpers for the select-decode checker.
// Provides FSM state enum, log kind codes, golden decode table, X test.
package sel_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] KIND_FAIL    = 2'b01;
   localparam logic [1:0] KIND_NOMATCH = 2'b10;

   localparam int LOG_W = 12;

   function automatic logic [7:0] golden(input logic [1:0] sel);
      logic [7:0] code;
      case (sel)
         2'b00:   code = 8'hA0;
         2'b01:   code = 8'hBB;
         2'b10:   code = 8'hAA;
         default: code = 8'hBC;
      endcase
      return code;
   endfunction

   // Only meaningful in a 4-state simulator; hardware sees it as false.
   function automatic logic sel_unknown(input logic [1:0] sel);
      return ((^sel) === 1'bx);
   endfunction

endpackage

// File: rtl/sel_decode_checker_log_fifo.sv
// sel_check_log_fifo: synchronous error-record FIFO, 12-bit entries.
// Ports: clk, rst_n, clr, push/wdata/push_ok, pop/rdata, full, empty.
module sel_check_log_fifo
   import sel_check_pkg::*;
#(
   parameter int LOG_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [LOG_W-1:0] wdata,
   output logic             push_ok,
   input  logic             pop,
   output logic [LOG_W-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(LOG_DEPTH);

   logic [LOG_W-1:0] mem [LOG_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees the slot a same-cycle push needs when full.
   assign do_pop  = pop && !empty;
   assign push_ok = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !clr && push_ok)
         mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Head reads as zero when empty so the log outputs are clean.
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sel_decode_checker.sv
// sel_decode_checker: classifies (sel, y) pairs against the golden table,
// keeps saturating pass/fail/no-match counts and logs errors in a FIFO.
// Ports: run control (start, num_items, mode_unique, busy, done),
// input stream (in_valid/in_ready, in_sel, in_y), statistics counters,
// log reader (log_valid/log_ready, log_sel, log_y, log_kind, log_overflow).
module sel_decode_checker
   import sel_check_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int LOG_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_items,
   input  logic             mode_unique,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [7:0]       in_y,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] nomatch_cnt,
   output logic             log_valid,
   input  logic             log_ready,
   output logic [1:0]       log_sel,
   output logic [7:0]       log_y,
   output logic [1:0]       log_kind,
   output logic             log_overflow
);

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic             mode_q;
   logic             xfer;
   logic             start_ok;
   logic             is_pass;
   logic             is_nm;
   logic [1:0]       kind;
   logic             push;
   logic             push_ok;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LOG_W-1:0] head;

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   assign start_ok = start && (state != RUN);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      is_pass = 1'b0;
      is_nm   = 1'b0;
      if (sel_unknown(in_sel))
         is_nm = 1'b1;
      else if (mode_q && (in_sel == 2'b00 || in_sel == 2'b11))
         is_nm = 1'b1;
      else if (in_y == golden(in_sel))
         is_pass = 1'b1;
      kind = is_nm ? KIND_NOMATCH : KIND_FAIL;
   end

   assign push = xfer && !is_pass;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rem    <= '0;
         mode_q <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (xfer) begin
                  rem <= rem - 1'b1;
                  if (rem == CNT_W'(1)) state <= DONE;
               end
            end
            default: begin
               if (start) begin
                  rem    <= num_items;
                  mode_q <= mode_unique;
                  state  <= (num_items == '0) ? DONE : RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || start_ok) begin
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         nomatch_cnt  <= '0;
         log_overflow <= 1'b0;
      end else if (xfer) begin
         if (is_pass && pass_cnt != '1)
            pass_cnt <= pass_cnt + 1'b1;
         if (!is_pass && !is_nm && fail_cnt != '1)
            fail_cnt <= fail_cnt + 1'b1;
         if (is_nm && nomatch_cnt != '1)
            nomatch_cnt <= nomatch_cnt + 1'b1;
         if (push && !push_ok)
            log_overflow <= 1'b1;
      end
   end

   sel_check_log_fifo #(
      .LOG_DEPTH (LOG_DEPTH)
   ) u_log (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start_ok),
      .push    (push),
      .wdata   ({in_sel, in_y, kind}),
      .push_ok (push_ok),
      .pop     (log_ready),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign log_valid = !fifo_empty;
   assign log_sel   = head[11:10];
   assign log_y     = head[9:2];
   assign log_kind  = head[1:0];

endmodule

// File: tb/tb_sel_decode_checker.sv
// Testbench for sel_decode_checker: random and directed runs, scoreboard
// of expected log records and a cycle-level model of run statistics.
module tb_sel_decode_checker;

   localparam int CNT_W     = 8;
   localparam int LOG_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_items = '0;
   logic             mode_unique = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_sel = '0;
   logic [7:0]       in_y = '0;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic [CNT_W-1:0] nomatch_cnt;
   logic             log_valid;
   logic             log_ready = 1'b0;
   logic [1:0]       log_sel;
   logic [7:0]       log_y;
   logic [1:0]       log_kind;
   logic             log_overflow;

   always #5 clk = ~clk;

   sel_decode_checker #(
      .CNT_W     (CNT_W),
      .LOG_DEPTH (LOG_DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .num_items    (num_items),
      .mode_unique  (mode_unique),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sel       (in_sel),
      .in_y         (in_y),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt),
      .fail_cnt     (fail_cnt),
      .nomatch_cnt  (nomatch_cnt),
      .log_valid    (log_valid),
      .log_ready    (log_ready),
      .log_sel      (log_sel),
      .log_y        (log_y),
      .log_kind     (log_kind),
      .log_overflow (log_overflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0] sel;
      logic [7:0] y;
      logic [1:0] kind;
   } rec_t;

   logic [7:0] gold_v [4] = '{8'hA0, 8'hBB, 8'hAA, 8'hBC};

   rec_t exp_q[$];
   rec_t r;
   int   m_st = 0;     // 0 idle, 1 running, 2 finished
   int   m_rem = 0;
   int   m_pass = 0;
   int   m_fail = 0;
   int   m_nm = 0;
   bit   m_ovf = 0;
   bit   m_mode = 0;
   bit   chk_en = 0;

   function automatic int sat(input int v);
      return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_st = 0; m_rem = 0;
         m_pass = 0; m_fail = 0; m_nm = 0;
         m_ovf = 0;
         exp_q.delete();
         chk_en = 1;
      end else if (m_st == 1) begin
         if (in_valid) begin
            r.sel = in_sel;
            r.y   = in_y;
            if ($isunknown(in_sel) ||
                (m_mode && (in_sel == 2'b00 || in_sel == 2'b11))) begin
               r.kind = 2'b10;
               m_nm = sat(m_nm);
            end else if (in_y == gold_v[in_sel]) begin
               r.kind = 2'b00;
               m_pass = sat(m_pass);
            end else begin
               r.kind = 2'b01;
               m_fail = sat(m_fail);
            end
            if (r.kind != 2'b00) begin
               if (exp_q.size() < LOG_DEPTH) exp_q.push_back(r);
               else m_ovf = 1;
            end
            m_rem--;
            if (m_rem == 0) m_st = 2;
         end
      end else if (start) begin
         m_pass = 0; m_fail = 0; m_nm = 0;
         m_ovf = 0;
         exp_q.delete();
         m_mode = mode_unique;
         m_rem = int'(num_items);
         m_st = (num_items == 0) ? 2 : 1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_st == 1);
         chk("busy", busy, m_st == 1);
         chk("done", done, m_st == 2);
         chk("pass_cnt", pass_cnt, m_pass);
         chk("fail_cnt", fail_cnt, m_fail);
         chk("nomatch_cnt", nomatch_cnt, m_nm);
         chk("log_overflow", log_overflow, m_ovf);
         chk("log_valid", log_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("log_sel", log_sel, exp_q[0].sel);
            chk("log_y", log_y, exp_q[0].y);
            chk("log_kind", log_kind, exp_q[0].kind);
            if (log_valid && log_ready) void'(exp_q.pop_front());
         end else begin
            chk("log_head_zero", {log_sel, log_y, log_kind}, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n, input bit m);
      start = 1'b1;
      num_items = CNT_W'(n);
      mode_unique = m;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [1:0] s, input logic [7:0] y);
      in_valid = 1'b1;
      in_sel = s;
      in_y = y;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int budget;
      logic [1:0] s;

      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_log_valid", log_valid, 0);

      // all four legal, correct codes
      do_start(4, 1'b0);
      chk("t1_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) send(2'(i), gold_v[i]);
      chk("t1_done", done, 1);
      chk("t1_busy", busy, 0);
      chk("t1_pass", pass_cnt, 4);
      chk("t1_fail", fail_cnt, 0);
      chk("t1_nm", nomatch_cnt, 0);
      chk("t1_log_valid", log_valid, 0);

      // unique mode: 00 and 11 become no-match
      do_start(4, 1'b1);
      for (int i = 0; i < 4; i++) send(2'(i), gold_v[i]);
      chk("t2_pass", pass_cnt, 2);
      chk("t2_nm", nomatch_cnt, 2);
      chk("t2_h0_sel", log_sel, 0);
      chk("t2_h0_y", log_y, 8'hA0);
      chk("t2_h0_kind", log_kind, 2);
      log_ready = 1'b1;
      step();
      chk("t2_h1_sel", log_sel, 3);
      chk("t2_h1_y", log_y, 8'hBC);
      chk("t2_h1_kind", log_kind, 2);
      step();
      log_ready = 1'b0;
      chk("t2_empty", log_valid, 0);

      // overflow: six fails into a four-entry log
      do_start(6, 1'b0);
      for (int i = 0; i < 6; i++) send(2'b01, 8'h00);
      chk("t3_fail", fail_cnt, 6);
      chk("t3_ovf", log_overflow, 1);
      log_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_pop_valid", log_valid, 1);
         chk("t3_pop_y", log_y, 0);
         chk("t3_pop_kind", log_kind, 1);
         step();
      end
      chk("t3_drained", log_valid, 0);
      log_ready = 1'b0;

      // unknown select bit
      do_start(1, 1'b0);
      send(2'bx1, 8'h55);
      chk("t4_log_valid", log_valid, 1);
      log_ready = 1'b1;
      step();
      log_ready = 1'b0;

      // random valid, random reader, ignored mid-run starts
      for (int run = 0; run < 5; run++) begin
         n = $urandom_range(8, 30);
         do_start(n, 1'($urandom_range(0, 1)));
         budget = 300;
         while (!done && budget > 0) begin
            in_valid = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            in_sel = s;
            in_y = ($urandom_range(0, 1) != 0) ? gold_v[s] : 8'($urandom);
            start = ($urandom_range(0, 7) == 0);
            num_items = 8'($urandom_range(0, 255));
            mode_unique = 1'($urandom_range(0, 1));
            log_ready = 1'($urandom_range(0, 1));
            step();
            budget--;
         end
         in_valid = 1'b0;
         start = 1'b0;
         chk("t5_reached_done", done, 1);
         chk("t5_total", pass_cnt + fail_cnt + nomatch_cnt, n);
         log_ready = 1'b1;
         repeat (LOG_DEPTH + 1) step();
         log_ready = 1'b0;
      end

      // reset mid-run
      do_start(8, 1'b0);
      send(2'b10, 8'h00);
      send(2'b00, 8'hA0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_ready", in_ready, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_pass", pass_cnt, 0);
      chk("t6_fail", fail_cnt, 0);
      chk("t6_log_valid", log_valid, 0);
      step();

      // empty run
      do_start(0, 1'b0);
      chk("t7_done", done, 1);
      chk("t7_ready", in_ready, 0);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
